// File: rtl/rectifier_pkg.sv
// Shared types and default sizing for the two-channel rectifier arbiter.
package rectifier_pkg;

    localparam int N_DEF       = 16;
    localparam int FRAME_DEF   = 42;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef logic ch_id_t;

endpackage

// File: rtl/rectifier_rr_grant.sv
// Two-way round-robin grant: on a tie the channel that was not served last wins.
module rectifier_rr_grant
    import rectifier_pkg::*;
(
    input  logic [1:0] valid_i,
    input  ch_id_t     last_grant_i,
    output ch_id_t     grant_o,
    output logic       any_o
);

    always_comb begin
        any_o   = |valid_i;
        grant_o = 1'b0;
        if (&valid_i) begin
            grant_o = ~last_grant_i;
        end else if (valid_i[1]) begin
            grant_o = 1'b1;
        end
    end

endmodule

// File: rtl/rectifier_arbiter.sv
// Shares one rectifier between two sample channels, one sample in flight at a time,
// with per-channel frame tracking and a stop-aware timeout on the rectifier result.
module rectifier_arbiter
    import rectifier_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int FRAME   = FRAME_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ch0_valid_i,
    input  logic [N-1:0] ch0_data_i,
    output logic         ch0_ready_o,
    input  logic         ch1_valid_i,
    input  logic [N-1:0] ch1_data_i,
    output logic         ch1_ready_o,
    output logic         rect_ready_o,
    output logic [N-1:0] rect_in_data_o,
    input  logic         rect_send_data_i,
    input  logic [N-1:0] rect_out_data_i,
    input  logic         rect_stop_i,
    output logic         res_valid_o,
    output logic [N-1:0] res_data_o,
    output logic         res_ch_o,
    output logic         res_last_o,
    output logic         err_timeout_o
);

    localparam int FW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [N-1:0]         hold_data_q, hold_data_d;
    ch_id_t               hold_ch_q, hold_ch_d;
    ch_id_t               last_grant_q, last_grant_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [1:0][FW-1:0]   frame_q, frame_d;
    logic                 res_valid_q, res_valid_d;
    logic [N-1:0]         res_data_q, res_data_d;
    ch_id_t               res_ch_q, res_ch_d;
    logic                 res_last_q, res_last_d;
    logic                 err_q, err_d;

    ch_id_t               grant;
    logic                 any_valid;
    logic                 at_last;

    rectifier_rr_grant u_grant (
        .valid_i      ({ch1_valid_i, ch0_valid_i}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .any_o        (any_valid)
    );

    assign at_last = (frame_q[hold_ch_q] == FW'(FRAME - 1));

    always_comb begin
        state_d        = state_q;
        hold_data_d    = hold_data_q;
        hold_ch_d      = hold_ch_q;
        last_grant_d   = last_grant_q;
        timer_d        = timer_q;
        frame_d        = frame_q;
        res_valid_d    = 1'b0;
        res_data_d     = res_data_q;
        res_ch_d       = res_ch_q;
        res_last_d     = res_last_q;
        err_d          = 1'b0;
        ch0_ready_o    = 1'b0;
        ch1_ready_o    = 1'b0;
        rect_ready_o   = 1'b0;
        rect_in_data_o = '0;

        case (state_q)
            IDLE: begin
                if (any_valid && !rect_stop_i) begin
                    ch0_ready_o = (grant == 1'b0);
                    ch1_ready_o = (grant == 1'b1);
                    hold_data_d = grant ? ch1_data_i : ch0_data_i;
                    hold_ch_d   = grant;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                rect_ready_o   = 1'b1;
                rect_in_data_o = hold_data_q;
                timer_d        = '0;
                state_d        = WAIT;
            end
            WAIT: begin
                if (rect_send_data_i) begin
                    res_valid_d          = 1'b1;
                    res_data_d           = rect_out_data_i;
                    res_ch_d             = hold_ch_q;
                    res_last_d           = at_last;
                    frame_d[hold_ch_q]   = at_last ? '0 : frame_q[hold_ch_q] + FW'(1);
                    last_grant_d         = hold_ch_q;
                    state_d              = IDLE;
                end else if (!rect_stop_i) begin
                    // Fires on the TIMEOUT-th unstalled cycle spent waiting.
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        err_d        = 1'b1;
                        last_grant_d = hold_ch_q;
                        state_d      = IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_data_q  <= '0;
            hold_ch_q    <= 1'b0;
            last_grant_q <= 1'b1;
            timer_q      <= '0;
            frame_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_ch_q     <= 1'b0;
            res_last_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_ch_q    <= hold_ch_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            frame_q      <= frame_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_ch_q     <= res_ch_d;
            res_last_q   <= res_last_d;
            err_q        <= err_d;
        end
    end

    assign res_valid_o   = res_valid_q;
    assign res_data_o    = res_data_q;
    assign res_ch_o      = res_ch_q;
    assign res_last_o    = res_last_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_rectifier_arbiter.sv
// Directed bench for rectifier_arbiter with a two-cycle absolute-value rectifier model.
module tb_rectifier_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ch0_valid = 1'b0, ch1_valid = 1'b0;
    logic [15:0] ch0_data = '0, ch1_data = '0;
    logic        ch0_ready, ch1_ready;
    logic        rect_ready;
    logic [15:0] rect_in_data;
    logic        rect_send_data = 1'b0;
    logic [15:0] rect_out_data = '0;
    logic        rect_stop = 1'b0;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_ch, res_last, err_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    int          cd = 0;
    logic [15:0] cap = '0;
    bit          model_en = 1'b1;

    always #5 clk = ~clk;

    rectifier_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .ch0_valid_i      (ch0_valid),
        .ch0_data_i       (ch0_data),
        .ch0_ready_o      (ch0_ready),
        .ch1_valid_i      (ch1_valid),
        .ch1_data_i       (ch1_data),
        .ch1_ready_o      (ch1_ready),
        .rect_ready_o     (rect_ready),
        .rect_in_data_o   (rect_in_data),
        .rect_send_data_i (rect_send_data),
        .rect_out_data_i  (rect_out_data),
        .rect_stop_i      (rect_stop),
        .res_valid_o      (res_valid),
        .res_data_o       (res_data),
        .res_ch_o         (res_ch),
        .res_last_o       (res_last),
        .err_timeout_o    (err_timeout)
    );

    typedef struct {
        logic v0, v1, stop;
        logic exp_r0, exp_r1;
    } gvec_t;

    typedef struct {
        logic [15:0] data;
        logic [15:0] exp_res;
    } tvec_t;

    function automatic logic [15:0] rabs(input logic [15:0] x);
        return x[15] ? (16'h0000 - x) : x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; the rectifier model answers two cycles after rect_ready.
    task automatic cycle();
        @(posedge clk);
        #1;
        rect_send_data = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0 && model_en) begin
                rect_send_data = 1'b1;
                rect_out_data  = rabs(cap);
            end
        end
        if (rect_ready === 1'b1) begin
            cd  = 2;
            cap = rect_in_data;
        end
    endtask

    task automatic run_sample(input bit ch, input logic [15:0] d, input logic [15:0] exp_res,
                              input bit exp_last, input string tag);
        bit got;
        int lat;
        if (ch) begin ch1_valid = 1'b1; ch1_data = d; end
        else    begin ch0_valid = 1'b1; ch0_data = d; end
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if ((ch ? ch1_ready : ch0_ready) === 1'b1) begin got = 1'b1; break; end
            cycle();
        end
        check({tag, " accept"}, 32'(got), 32'd1);
        cycle();
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        #1;
        check({tag, " rect_ready"}, 32'(rect_ready), 32'd1);
        check({tag, " rect_in_data"}, 32'(rect_in_data), 32'(d));
        got = 1'b0;
        lat = 0;
        for (int n = 0; n < 10; n++) begin
            cycle();
            lat++;
            #1;
            if (res_valid === 1'b1) begin got = 1'b1; break; end
        end
        check({tag, " res_valid"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " res_data"}, 32'(res_data), 32'(exp_res));
        check({tag, " res_ch"}, 32'(res_ch), 32'(ch));
        check({tag, " res_last"}, 32'(res_last), 32'(exp_last));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        gvec_t gv[7];
        tvec_t tv[5];
        int acc, nres, errk, errcnt;
        bit lastg, g, both, resbad;

        gv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        gv[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        gv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        gv[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        gv[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        gv[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        gv[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        tv[0] = '{16'h7FFF, 16'h7FFF};
        tv[1] = '{16'hFFFF, 16'h0001};
        tv[2] = '{16'h0000, 16'h0000};
        tv[3] = '{16'h8000, 16'h8000};
        tv[4] = '{16'hFC18, 16'h03E8};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst ch0_ready", 32'(ch0_ready), 0);
        check("rst ch1_ready", 32'(ch1_ready), 0);
        check("rst rect_ready", 32'(rect_ready), 0);
        check("rst rect_in_data", 32'(rect_in_data), 0);
        check("rst res_valid", 32'(res_valid), 0);
        check("rst res_data", 32'(res_data), 0);
        check("rst res_ch", 32'(res_ch), 0);
        check("rst res_last", 32'(res_last), 0);
        check("rst err_timeout", 32'(err_timeout), 0);
        rst = 1'b0;
        cycle();

        // Combinational grant in IDLE; valids drop before the edge so nothing is accepted
        for (int i = 0; i < 7; i++) begin
            ch0_valid = gv[i].v0;
            ch1_valid = gv[i].v1;
            rect_stop = gv[i].stop;
            #1;
            check($sformatf("grant vec%0d ch0_ready", i), 32'(ch0_ready), 32'(gv[i].exp_r0));
            check($sformatf("grant vec%0d ch1_ready", i), 32'(ch1_ready), 32'(gv[i].exp_r1));
            ch0_valid = 1'b0;
            ch1_valid = 1'b0;
            rect_stop = 1'b0;
            cycle();
        end

        // Fairness: both channels continuously valid
        ch0_valid = 1'b1; ch1_valid = 1'b1;
        ch0_data = 16'h0011; ch1_data = 16'h0022;
        acc = 0; nres = 0; lastg = 1'b0; both = 1'b0;
        for (int k = 0; k < 80 && nres < 6; k++) begin
            #1;
            if (ch0_ready === 1'b1 && ch1_ready === 1'b1) both = 1'b1;
            if (ch0_ready === 1'b1 || ch1_ready === 1'b1) begin
                g = (ch1_ready === 1'b1);
                if (acc > 0) check("fair alternate grant", 32'(g), 32'(!lastg));
                lastg = g;
                acc++;
            end
            cycle();
            if (acc >= 6) begin ch0_valid = 1'b0; ch1_valid = 1'b0; end
            if (res_valid === 1'b1) begin
                check($sformatf("fair res_ch #%0d", nres), 32'(res_ch), 32'(nres % 2));
                nres++;
            end
        end
        check("fair both ready", 32'(both), 0);
        check("fair results", 32'(nres), 6);
        check("fair accepts", 32'(acc), 6);
        repeat (3) cycle();

        // Single issue of -300
        run_sample(1'b0, 16'hFED4, 16'd300, 1'b0, "single");

        // Stall in IDLE
        ch1_valid = 1'b1;
        ch1_data  = 16'hFF00;
        rect_stop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall ch1_ready c%0d", i), 32'(ch1_ready), 0);
            check($sformatf("stall rect_ready c%0d", i), 32'(rect_ready), 0);
            cycle();
        end
        rect_stop = 1'b0;
        #1;
        check("stall release ch1_ready", 32'(ch1_ready), 1);
        run_sample(1'b1, 16'hFF00, 16'h0100, 1'b0, "stall");

        // Timeout with three stop cycles in WAIT and stop held during ISSUE
        model_en = 1'b0;
        ch0_valid = 1'b1;
        ch0_data  = 16'h1234;
        #1;
        check("tmo accept", 32'(ch0_ready), 1);
        cycle();
        ch0_valid = 1'b0;
        rect_stop = 1'b1;
        #1;
        check("tmo rect_ready under stop", 32'(rect_ready), 1);
        errk = -1; errcnt = 0; resbad = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            cycle();
            rect_stop = (k >= 4 && k <= 6);
            #1;
            if (res_valid === 1'b1) resbad = 1'b1;
            if (err_timeout === 1'b1) begin
                errcnt++;
                if (errk < 0) errk = k;
            end
        end
        rect_stop = 1'b0;
        check("tmo err cycle", 32'(errk), 19);
        check("tmo err pulses", 32'(errcnt), 1);
        check("tmo no result", 32'(resbad), 0);
        model_en = 1'b1;
        run_sample(1'b0, 16'h0005, 16'h0005, 1'b0, "post-tmo");

        // Reset during WAIT, then a late send_data
        model_en = 1'b0;
        ch0_valid = 1'b1;
        ch0_data  = 16'h0AAA;
        #1;
        check("rstw accept", 32'(ch0_ready), 1);
        cycle();
        ch0_valid = 1'b0;
        #1;
        check("rstw rect_ready", 32'(rect_ready), 1);
        cycle();
        rst = 1'b1;
        #1;
        check("rstw rect_ready", 32'(rect_ready), 0);
        check("rstw rect_in_data", 32'(rect_in_data), 0);
        check("rstw res_valid", 32'(res_valid), 0);
        check("rstw err", 32'(err_timeout), 0);
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        rect_send_data = 1'b1;
        rect_out_data  = 16'h5555;
        resbad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            #1;
            if (res_valid !== 1'b0 || err_timeout !== 1'b0 || rect_ready !== 1'b0) resbad = 1'b1;
        end
        check("rstw late send ignored", 32'(resbad), 0);
        model_en = 1'b1;
        run_sample(1'b1, 16'hFFF6, 16'h000A, 1'b0, "post-rst");

        // Transaction table on channel 1 (ch1 frame count ends at 6)
        for (int i = 0; i < 5; i++) begin
            run_sample(1'b1, tv[i].data, tv[i].exp_res, 1'b0, $sformatf("tvec%0d", i));
        end

        // Advance channel 1 to position 41, then a full channel 0 frame plus one
        for (int i = 6; i < 41; i++) begin
            run_sample(1'b1, 16'(i), 16'(i), 1'b0, $sformatf("ch1 pre%0d", i));
        end
        for (int i = 0; i < 43; i++) begin
            run_sample(1'b0, 16'(-(i + 1)), 16'(i + 1), (i == 41), $sformatf("frame%0d", i + 1));
        end
        run_sample(1'b1, 16'h0042, 16'h0042, 1'b1, "ch1 last");
        run_sample(1'b1, 16'h0043, 16'h0043, 1'b0, "ch1 wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
